// File: rtl/lc3_mem_responder_if.sv
// Bus between the LC3 core (or bench) and the memory responder: fetch port,
// data port and the side preload port.
interface lc3_mem_if;
  // Instruction fetch port
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;

  // Data access port
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic        Data_rd;
  logic        data_req;
  logic [15:0] Data_dout;
  logic        complete_data;

  // Preload port
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  modport master (
    output pc, instrmem_rd,
    output Data_addr, Data_din, Data_rd, data_req,
    output load_en, load_addr, load_data,
    input  Instr_dout, complete_instr, Data_dout, complete_data
  );

  modport slave (
    input  pc, instrmem_rd,
    input  Data_addr, Data_din, Data_rd, data_req,
    input  load_en, load_addr, load_data,
    output Instr_dout, complete_instr, Data_dout, complete_data
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// Instruction/data memory responder for the LC3 core. Each port is either
// zero-wait (combinational read) or has a fixed latency of T cycles handled
// by its own IDLE/BUSY/DONE FSM. A side port preloads the array.
module lc3_mem_responder #(
  parameter logic [15:0] BASE_ADDR = 16'h3000,
  parameter int unsigned MEM_AW    = 10,
  parameter int unsigned T_FETCH   = 0,
  parameter int unsigned T_DATA    = 0
) (
  input  logic        clock,
  input  logic        reset,
  lc3_mem_if.slave    bus
);

  localparam int unsigned DEPTH = 2 ** MEM_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [15:0] mem [DEPTH];

  // Data-port write request into the array, driven by whichever data mode is built
  logic              d_we;
  logic [MEM_AW-1:0] d_widx;
  logic [15:0]       d_wdata;

  // LC3 address to array index; out-of-window addresses alias by design
  function automatic logic [MEM_AW-1:0] to_index(input logic [15:0] addr);
    return MEM_AW'(addr - BASE_ADDR);
  endfunction

  // Array writes: preload is issued last so it wins over a same-index data write
  always_ff @(posedge clock) begin
    if (d_we) begin
      mem[d_widx] <= d_wdata;
    end
    if (bus.load_en) begin
      mem[to_index(bus.load_addr)] <= bus.load_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction port
  // ---------------------------------------------------------------------------
  if (T_FETCH == 0) begin : g_instr_comb
    // Zero-wait fetch: the request level is not needed
    logic unused_instr_rd;
    assign unused_instr_rd     = bus.instrmem_rd;
    assign bus.Instr_dout      = reset ? 16'h0000 : mem[to_index(bus.pc)];
    assign bus.complete_instr  = ~reset;
  end else begin : g_instr_fsm
    localparam logic [3:0] T_LOAD = 4'(T_FETCH - 1);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [MEM_AW-1:0] addr_q, addr_nx;
    logic              enter_done;

    // Next-state: capture on request, count down, one-cycle DONE
    always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      addr_nx    = addr_q;
      enter_done = 1'b0;
      case (state)
        IDLE: begin
          if (bus.instrmem_rd) begin
            addr_nx = to_index(bus.pc);
            cnt_nx  = T_LOAD;
            if (T_FETCH == 1) begin
              state_nx   = DONE;
              enter_done = 1'b1;
            end else begin
              state_nx = BUSY;
            end
          end
        end
        BUSY: begin
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nx   = DONE;
            enter_done = 1'b1;
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end

    // State, capture registers and registered read on entry to DONE
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state              <= IDLE;
        cnt                <= 4'd0;
        addr_q             <= '0;
        bus.Instr_dout     <= 16'h0000;
        bus.complete_instr <= 1'b0;
      end else begin
        state              <= state_nx;
        cnt                <= cnt_nx;
        addr_q             <= addr_nx;
        bus.complete_instr <= enter_done;
        if (enter_done) begin
          bus.Instr_dout <= mem[addr_nx];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data port
  // ---------------------------------------------------------------------------
  if (T_DATA == 0) begin : g_data_comb
    // Zero-wait access: writes commit on every edge the request is held
    assign d_we              = bus.data_req & ~bus.Data_rd & ~reset;
    assign d_widx            = to_index(bus.Data_addr);
    assign d_wdata           = bus.Data_din;
    assign bus.Data_dout     = reset ? 16'h0000 : mem[to_index(bus.Data_addr)];
    assign bus.complete_data = ~reset;
  end else begin : g_data_fsm
    localparam logic [3:0] T_LOAD = 4'(T_DATA - 1);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [MEM_AW-1:0] addr_q, addr_nx;
    logic [15:0]       din_q, din_nx;
    logic              rd_q, rd_nx;
    logic              enter_done;

    // Next-state: capture address/data/direction on request, count down, one-cycle DONE
    always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      addr_nx    = addr_q;
      din_nx     = din_q;
      rd_nx      = rd_q;
      enter_done = 1'b0;
      case (state)
        IDLE: begin
          if (bus.data_req) begin
            addr_nx = to_index(bus.Data_addr);
            din_nx  = bus.Data_din;
            rd_nx   = bus.Data_rd;
            cnt_nx  = T_LOAD;
            if (T_DATA == 1) begin
              state_nx   = DONE;
              enter_done = 1'b1;
            end else begin
              state_nx = BUSY;
            end
          end
        end
        BUSY: begin
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nx   = DONE;
            enter_done = 1'b1;
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end

    // Write commits on the edge that enters DONE; reset drops an in-flight write
    assign d_we    = enter_done & ~rd_nx & ~reset;
    assign d_widx  = addr_nx;
    assign d_wdata = din_nx;

    // State, capture registers and registered read on entry to DONE
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state             <= IDLE;
        cnt               <= 4'd0;
        addr_q            <= '0;
        din_q             <= 16'h0000;
        rd_q              <= 1'b0;
        bus.Data_dout     <= 16'h0000;
        bus.complete_data <= 1'b0;
      end else begin
        state             <= state_nx;
        cnt               <= cnt_nx;
        addr_q            <= addr_nx;
        din_q             <= din_nx;
        rd_q              <= rd_nx;
        bus.complete_data <= enter_done;
        if (enter_done && rd_nx) begin
          bus.Data_dout <= mem[addr_nx];
        end
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: one zero-wait instance checked directly and
// one instance with T_FETCH=3/T_DATA=2 checked through a scoreboard.
module tb_lc3_mem_responder;

  localparam int unsigned T_F = 3;
  localparam int unsigned T_D = 2;

  typedef struct packed {
    logic        rd;
    logic [15:0] val;
  } dexp_t;

  logic clock;
  logic reset;

  lc3_mem_if bus_z ();
  lc3_mem_if bus_t ();

  lc3_mem_responder #(.BASE_ADDR(16'h3000), .MEM_AW(10), .T_FETCH(0), .T_DATA(0)) u_dut_z (
    .clock (clock),
    .reset (reset),
    .bus   (bus_z)
  );

  lc3_mem_responder #(.BASE_ADDR(16'h3000), .MEM_AW(10), .T_FETCH(T_F), .T_DATA(T_D)) u_dut_t (
    .clock (clock),
    .reset (reset),
    .bus   (bus_t)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] iq[$];
  dexp_t       dq[$];
  logic [15:0] last_rd = 16'h0000;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard for the instruction port of the latency instance
  always @(negedge clock) begin : mon_instr
    logic [15:0] e;
    if (bus_t.complete_instr === 1'b1) begin
      if (iq.size() == 0) begin
        check("instr_unexpected", 16'd1, 16'd0);
      end else begin
        e = iq.pop_front();
        check("sb_instr", bus_t.Instr_dout, e);
      end
    end
  end

  // Scoreboard for the data port: reads return data, writes leave Data_dout held
  always @(negedge clock) begin : mon_data
    dexp_t e;
    if (bus_t.complete_data === 1'b1) begin
      if (dq.size() == 0) begin
        check("data_unexpected", 16'd1, 16'd0);
      end else begin
        e = dq.pop_front();
        if (e.rd) begin
          check("sb_data_rd", bus_t.Data_dout, e.val);
          last_rd = e.val;
        end else begin
          check("sb_data_wr_hold", bus_t.Data_dout, last_rd);
        end
      end
    end
  end

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    bus_z.load_en = 1'b1; bus_z.load_addr = a; bus_z.load_data = d;
    bus_t.load_en = 1'b1; bus_t.load_addr = a; bus_t.load_data = d;
    @(negedge clock);
    bus_z.load_en = 1'b0;
    bus_t.load_en = 1'b0;
  endtask

  // Fetch on the latency instance; pc/request are scrambled after capture
  task automatic t_instr(input logic [15:0] a, input logic [15:0] exp);
    int n;
    bus_t.pc = a;
    bus_t.instrmem_rd = 1'b1;
    iq.push_back(exp);
    check("t_ci_before", 16'(bus_t.complete_instr), 16'd0);
    @(negedge clock);
    bus_t.instrmem_rd = 1'b0;
    bus_t.pc = a ^ 16'h0300;
    n = 1;
    while (bus_t.complete_instr !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("t_instr_latency", 16'(n), 16'(T_F));
    check("t_instr_dout", bus_t.Instr_dout, exp);
    @(negedge clock);
    check("t_ci_one_cycle", 16'(bus_t.complete_instr), 16'd0);
  endtask

  // Data access on the latency instance; inputs are scrambled after capture
  task automatic t_data(input logic [15:0] a, input logic [15:0] d, input logic rd,
                        input logic [15:0] exp);
    int    n;
    dexp_t e;
    e.rd  = rd;
    e.val = exp;
    bus_t.Data_addr = a;
    bus_t.Data_din  = d;
    bus_t.Data_rd   = rd;
    bus_t.data_req  = 1'b1;
    dq.push_back(e);
    check("t_cd_before", 16'(bus_t.complete_data), 16'd0);
    @(negedge clock);
    bus_t.data_req  = 1'b0;
    bus_t.Data_addr = a ^ 16'h0300;
    bus_t.Data_din  = ~d;
    bus_t.Data_rd   = ~rd;
    n = 1;
    while (bus_t.complete_data !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("t_data_latency", 16'(n), 16'(T_D));
    @(negedge clock);
    check("t_cd_one_cycle", 16'(bus_t.complete_data), 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus_z.pc = 16'h0; bus_z.instrmem_rd = 1'b0;
    bus_z.Data_addr = 16'h0; bus_z.Data_din = 16'h0; bus_z.Data_rd = 1'b1; bus_z.data_req = 1'b0;
    bus_z.load_en = 1'b0; bus_z.load_addr = 16'h0; bus_z.load_data = 16'h0;
    bus_t.pc = 16'h0; bus_t.instrmem_rd = 1'b0;
    bus_t.Data_addr = 16'h0; bus_t.Data_din = 16'h0; bus_t.Data_rd = 1'b1; bus_t.data_req = 1'b0;
    bus_t.load_en = 1'b0; bus_t.load_addr = 16'h0; bus_t.load_data = 16'h0;

    @(negedge clock);
    // Preload while reset is held
    load_word(16'h3000, 16'h1261);
    load_word(16'h3001, 16'h5020);
    load_word(16'h3004, 16'h0F0F);
    load_word(16'h3050, 16'hCAFE);
    load_word(16'h3100, 16'h0000);
    load_word(16'h3200, 16'h7777);

    check("rst_z_ci", 16'(bus_z.complete_instr), 16'd0);
    check("rst_z_cd", 16'(bus_z.complete_data), 16'd0);
    check("rst_t_ci", 16'(bus_t.complete_instr), 16'd0);
    check("rst_t_cd", 16'(bus_t.complete_data), 16'd0);
    check("rst_t_idout", bus_t.Instr_dout, 16'h0000);
    check("rst_t_ddout", bus_t.Data_dout, 16'h0000);

    reset = 1'b0;

    // Zero-wait fetches, including an aliased address
    bus_z.pc = 16'h3000; #1;
    check("z_fetch_3000", bus_z.Instr_dout, 16'h1261);
    check("z_ci", 16'(bus_z.complete_instr), 16'd1);
    bus_z.pc = 16'h3001; #1;
    check("z_fetch_3001", bus_z.Instr_dout, 16'h5020);
    bus_z.pc = 16'h3404; #1;
    check("z_fetch_alias", bus_z.Instr_dout, 16'h0F0F);

    // Zero-wait write then read
    @(negedge clock);
    bus_z.Data_addr = 16'h3020; bus_z.Data_din = 16'hABCD; bus_z.Data_rd = 1'b0; bus_z.data_req = 1'b1;
    @(negedge clock);
    bus_z.Data_rd = 1'b1; #1;
    check("z_data_rd", bus_z.Data_dout, 16'hABCD);
    check("z_cd", 16'(bus_z.complete_data), 16'd1);

    // Same-edge preload and data write to one index: preload wins
    @(negedge clock);
    bus_z.load_en = 1'b1; bus_z.load_addr = 16'h3010; bus_z.load_data = 16'hAAAA;
    bus_z.Data_addr = 16'h3010; bus_z.Data_din = 16'h5555; bus_z.Data_rd = 1'b0; bus_z.data_req = 1'b1;
    @(negedge clock);
    bus_z.load_en = 1'b0;
    bus_z.Data_rd = 1'b1; #1;
    check("z_load_wins", bus_z.Data_dout, 16'hAAAA);
    bus_z.data_req = 1'b0;

    // Latency instance: fetches
    @(negedge clock);
    t_instr(16'h3001, 16'h5020);
    t_instr(16'h3404, 16'h0F0F);

    // Write whose address changes during BUSY, then read back both locations
    t_data(16'h3100, 16'hBEEF, 1'b0, 16'h0000);
    t_data(16'h3100, 16'h0000, 1'b1, 16'hBEEF);
    t_data(16'h3200, 16'h0000, 1'b1, 16'h7777);

    // Both ports at once
    fork
      t_instr(16'h3000, 16'h1261);
      t_data(16'h3001, 16'h0000, 1'b1, 16'h5020);
    join

    // Reset in the middle of a write
    bus_t.Data_addr = 16'h3050; bus_t.Data_din = 16'h1234; bus_t.Data_rd = 1'b0; bus_t.data_req = 1'b1;
    @(negedge clock);
    bus_t.data_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_cd", 16'(bus_t.complete_data), 16'd0);
    check("midrst_ddout", bus_t.Data_dout, 16'h0000);
    check("midrst_idout", bus_t.Instr_dout, 16'h0000);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    last_rd = 16'h0000;
    t_data(16'h3050, 16'h0000, 1'b1, 16'hCAFE);

    repeat (3) @(negedge clock);
    check("sb_instr_drained", 16'(iq.size()), 16'd0);
    check("sb_data_drained", 16'(dq.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
